// File: rtl/seq_restoring_divider.sv
// Purpose: sequential unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Latency: done high after WIDTH+1 edges from start sampling; one edge when the divisor is zero.
// Backpressure: start is ignored while busy; results are held until the next division completes.
`timescale 1ns/1ps
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_q;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] r_div;      // divisor captured at start
  logic [CW-1:0]    r_cnt;      // restoring steps still to do
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dbz;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // A new division may launch from IDLE or from the single FIN cycle.
  assign w_accept   = i_start & ((r_state == S_IDLE) | (r_state == S_FIN));
  assign w_div_zero = (i_divisor == '0);
  assign w_last     = (r_cnt == CW'(1));

  // One restoring step: shift {R,Q} left and trial-subtract the divisor.
  // The partial remainder stays below the divisor, so the shifted value fits
  // WIDTH+1 bits and a non-negative difference always fits WIDTH bits; the two
  // top bits of the difference being zero therefore means "no borrow".
  assign w_rem_sh  = {r_rem, r_q[WIDTH-1]};
  assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_div};
  assign w_ge      = (w_diff[WIDTH+1:WIDTH] == 2'b00);
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_q_nxt   = {r_q[WIDTH-2:0], w_ge};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a zero divisor skips RUN and reports in FIN directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (w_accept) begin
          w_state_nxt = w_div_zero ? S_FIN : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_FIN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration, and result registers updated on entry to FIN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem     <= '0;
      r_q       <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      if (w_div_zero) begin
        r_quot    <= '1;
        r_rem_out <= i_dividend;
        r_dbz     <= 1'b1;
      end else begin
        r_rem <= '0;
        r_q   <= i_dividend;
        r_div <= i_divisor;
        r_cnt <= CW'(WIDTH);
      end
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_quot    <= w_q_nxt;
        r_rem_out <= w_rem_nxt;
        r_dbz     <= 1'b0;
      end
    end
  end

  assign o_busy        = (r_state == S_RUN);
  assign o_done        = (r_state == S_FIN);
  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem_out;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for the 4-bit restoring divider: reset, latency, corner values,
// divide-by-zero, busy-ignore, reset abort, and all 256 operand pairs back-to-back.
`timescale 1ns/1ps
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks;
  int n_fail;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start; returns #1 after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded at 20.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #12;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero", {busy, done, div_by_zero, quotient, remainder});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int n;
    launch(4'd13, 4'd3);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_on_accept: got %b expected 1", busy);
    end
    wait_done(n);
    n_checks++;
    if (n !== W) begin
      n_fail++;
      $display("FAIL latency_13_3: got %0d edges after accept expected %0d", n, W);
    end
    n_checks++;
    if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL result_13_3: got q=%0d r=%0d dbz=%b busy=%b expected q=4 r=1 dbz=0 busy=0",
               quotient, remainder, div_by_zero, busy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
      n_fail++;
      $display("FAIL hold_13_3: got done=%b q=%0d r=%0d expected done=0 q=4 r=1", done, quotient, remainder);
    end
  endtask

  task automatic test_corners();
    int n;
    launch(4'd15, 4'd1);
    wait_done(n);
    n_checks++;
    if (n !== W || quotient !== 4'd15 || remainder !== 4'd0) begin
      n_fail++;
      $display("FAIL result_15_1: got n=%0d q=%0d r=%0d expected n=4 q=15 r=0", n, quotient, remainder);
    end
    launch(4'd3, 4'd9);
    wait_done(n);
    n_checks++;
    if (n !== W || quotient !== 4'd0 || remainder !== 4'd3) begin
      n_fail++;
      $display("FAIL result_3_9: got n=%0d q=%0d r=%0d expected n=4 q=0 r=3", n, quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int n;
    launch(4'd7, 4'd0);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_handshake: got busy=%b done=%b expected busy=0 done=1", busy, done);
    end
    n_checks++;
    if (quotient !== 4'hF || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b expected q=15 r=7 dbz=1", quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_after: got done=%b busy=%b dbz=%b expected 0 0 1", done, busy, div_by_zero);
    end
    n = 0;
  endtask

  task automatic test_busy_ignore();
    int n;
    int total;
    launch(4'd12, 4'd5);
    total = 0;
    @(posedge clk);
    #1;
    total++;
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 4'd2;
    @(posedge clk);
    #1;
    total++;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_midrun: got %b expected 1", busy);
    end
    wait_done(n);
    total += n;
    n_checks++;
    if (total !== W || quotient !== 4'd2 || remainder !== 4'd2) begin
      n_fail++;
      $display("FAIL ignore_start: got n=%0d q=%0d r=%0d expected n=4 q=2 r=2", total, quotient, remainder);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int seen_done;
    launch(4'd14, 4'd3);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 11'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b expected all zero", {busy, done, div_by_zero, quotient, remainder});
    end
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done cycles expected 0", seen_done);
    end
    launch(4'd14, 4'd3);
    wait_done(n);
    n_checks++;
    if (n !== W || quotient !== 4'd4 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL result_14_3: got n=%0d q=%0d r=%0d dbz=%b expected n=4 q=4 r=2 dbz=0",
               n, quotient, remainder, div_by_zero);
    end
  endtask

  // Every pair; each new start is driven during the FIN cycle of the previous one.
  task automatic test_back_to_back();
    int n;
    int a;
    int b;
    int exp_n;
    @(posedge clk);
    #1;
    for (int idx = 0; idx < 256; idx++) begin
      a = idx / 16;
      b = idx % 16;
      start    = 1'b1;
      dividend = W'(a);
      divisor  = W'(b);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n);
      exp_n = (b == 0) ? 0 : W;
      n_checks++;
      if (n !== exp_n) begin
        n_fail++;
        $display("FAIL b2b_latency %0d/%0d: got %0d expected %0d", a, b, n, exp_n);
      end
      if (b == 0) begin
        n_checks++;
        if (quotient !== 4'hF || int'(remainder) !== a || div_by_zero !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_dbz %0d/0: got q=%0d r=%0d dbz=%b expected q=15 r=%0d dbz=1",
                   a, quotient, remainder, div_by_zero, a);
        end
      end else begin
        n_checks++;
        if (int'(quotient) * b + int'(remainder) !== a || int'(remainder) >= b) begin
          n_fail++;
          $display("FAIL b2b_identity %0d/%0d: got q=%0d r=%0d", a, b, quotient, remainder);
        end
        n_checks++;
        if (int'(quotient) !== a / b || int'(remainder) !== a % b || div_by_zero !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_exact %0d/%0d: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=0",
                   a, b, quotient, remainder, div_by_zero, a / b, a % b);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
